reg_alu_seq: RTL

Parametrised successor of the 16-bit register-file/ALU datapath. It contains a register file (NREGS x WIDTH), an 8-op ALU with registered carry and zero flags, and a program counter with relative jump. Commands arrive over a valid/ready handshake and execute in two cycles: operand read, then execute/writeback. It sits between the instruction decoder and the data memory path of the next-generation microprocessor.

---
 rtl/reg_alu_pkg.sv | 22 ++
 rtl/reg_alu_seq_if.sv | 27 ++
 rtl/reg_file_p.sv | 38 +++
 rtl/reg_alu_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/reg_alu_pkg.sv
// Shared types for the register-file/ALU sequencer: opcodes and FSM states.
package reg_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_ADC = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_MOV = 3'd6,
    OP_JMP = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage : reg_alu_pkg

// File: rtl/reg_alu_seq_if.sv
// Command bus between the instruction decoder (master) and reg_alu_seq (slave).
interface reg_alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_rs_a;
  logic [AW-1:0]    cmd_rs_b;
  logic [AW-1:0]    cmd_rd;
  logic             cmd_wr;
  logic             cmd_imm_sel;
  logic [WIDTH-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_rs_a, cmd_rs_b, cmd_rd, cmd_wr, cmd_imm_sel, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs_a, cmd_rs_b, cmd_rd, cmd_wr, cmd_imm_sel, cmd_imm,
    output cmd_ready
  );

endinterface : reg_alu_seq_if

// File: rtl/reg_file_p.sv
// Register file: two combinational operand read ports, one debug read port,
// one synchronous write port; every entry clears on async reset.
module reg_file_p #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic [AW-1:0]    i_raddr_b,
  input  logic [AW-1:0]    i_raddr_dbg,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic [WIDTH-1:0] o_rdata_dbg
);

  logic [WIDTH-1:0] r_mem [NREGS];

  assign o_rdata_a   = r_mem[i_raddr_a];
  assign o_rdata_b   = r_mem[i_raddr_b];
  assign o_rdata_dbg = r_mem[i_raddr_dbg];

  // Storage: clear all entries on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule : reg_file_p

// File: rtl/reg_alu_seq.sv
// Two-cycle command sequencer: operand read in IDLE, execute/writeback in EXEC.
// Holds the ALU, the carry/zero flags and the program counter.
module reg_alu_seq
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  reg_alu_seq_if.slave     cmd,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic [WIDTH-1:0] pc,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           r_state;
  logic             r_ready;
  op_e              r_op;
  logic [AW-1:0]    r_rd;
  logic             r_wr;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
  logic [WIDTH-1:0] r_pc;
  logic             r_done;

  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;
  logic             w_we;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_cout;
  logic             w_alu_zero;

  // Writeback happens on the EXEC edge, so the next command's IDLE read sees it.
  assign w_we = (r_state == ST_EXEC) && r_wr && (r_op != OP_JMP);

  reg_file_p #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_rf (
    .clk         (clk),
    .rst_n       (reset),
    .i_raddr_a   (cmd.cmd_rs_a),
    .i_raddr_b   (cmd.cmd_rs_b),
    .i_raddr_dbg (dbg_addr),
    .i_we        (w_we),
    .i_waddr     (r_rd),
    .i_wdata     (w_alu_res),
    .o_rdata_a   (w_rdata_a),
    .o_rdata_b   (w_rdata_b),
    .o_rdata_dbg (dbg_data)
  );

  // ALU on the latched operands; carry comes from bit WIDTH of the widened sum.
  always_comb begin
    w_sum      = '0;
    w_alu_res  = r_result;
    w_alu_cout = r_cout;
    case (r_op)
      OP_ADD: begin
        w_sum      = {1'b0, r_opa} + {1'b0, r_opb};
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sum      = {1'b0, r_opa} + {1'b0, ~r_opb} + (WIDTH+1)'(1);
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
      end
      OP_ADC: begin
        w_sum      = {1'b0, r_opa} + {1'b0, r_opb} + (WIDTH+1)'(r_cout);
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
      end
      OP_AND: begin
        w_alu_res  = r_opa & r_opb;
        w_alu_cout = 1'b0;
      end
      OP_OR: begin
        w_alu_res  = r_opa | r_opb;
        w_alu_cout = 1'b0;
      end
      OP_XOR: begin
        w_alu_res  = r_opa ^ r_opb;
        w_alu_cout = 1'b0;
      end
      OP_MOV: begin
        w_alu_res  = r_imm;
        w_alu_cout = r_cout;
      end
      default: begin
        w_alu_res  = r_result;
        w_alu_cout = r_cout;
      end
    endcase
    if (w_alu_res == '0) begin
      w_alu_zero = 1'b1;
    end else begin
      w_alu_zero = 1'b0;
    end
  end

  // Control FSM: accept in IDLE, retire in EXEC; all visible outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_op     <= OP_ADD;
      r_rd     <= '0;
      r_wr     <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_imm    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_pc     <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (cmd.cmd_valid) begin
            r_op    <= op_e'(cmd.cmd_op);
            r_rd    <= cmd.cmd_rd;
            r_wr    <= cmd.cmd_wr;
            r_opa   <= w_rdata_a;
            r_opb   <= cmd.cmd_imm_sel ? cmd.cmd_imm : w_rdata_b;
            r_imm   <= cmd.cmd_imm;
            r_state <= ST_EXEC;
            r_ready <= 1'b0;
          end
        end
        ST_EXEC: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          if (r_op == OP_JMP) begin
            r_pc <= r_pc + r_imm;
          end else begin
            r_pc     <= r_pc + WIDTH'(1);
            r_result <= w_alu_res;
            r_cout   <= w_alu_cout;
            r_zero   <= w_alu_zero;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign done          = r_done;
  assign result        = r_result;
  assign cout          = r_cout;
  assign zero          = r_zero;
  assign pc            = r_pc;

endmodule : reg_alu_seq
